uart_autobaud_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync_edge.sv | 35 +++
 rtl/uart_autobaud_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared widths, defaults, rounding constants and the autobaud
//               state encoding for the UART autobaud controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DVSR_W       = 11;
    localparam int CNT_W        = 19;
    localparam int DEFAULT_DVSR = 650;

    // A 0x55 frame gives SYNC_BITS bit-times between the first and last
    // falling edges. The baud generator ticks 16x per bit, so
    // dvsr + 1 = N / (16 * SYNC_BITS) = N >> Q_SHIFT, rounded.
    localparam int SYNC_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int Q_SHIFT    = $clog2(OVERSAMPLE * SYNC_BITS);
    localparam int ROUND_C    = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_CALC    = 2'd3
    } ab_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync_edge
// Description : Two-flop synchronizer for the asynchronous rx pin followed by
//               a one-cycle falling-edge pulse. Idle (and reset) level is 1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic fe_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize rx and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fe_o = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_ctrl
// Description : Measures a 0x55 sync character on rx and derives the baud
//               generator divisor dvsr = round(N/128) - 1, where N is the
//               clock count spanning eight bit-times.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_autobaud_ctrl #(
    parameter int DVSR_W       = uart_pkg::DVSR_W,
    parameter int CNT_W        = uart_pkg::CNT_W,
    parameter int DEFAULT_DVSR = uart_pkg::DEFAULT_DVSR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    input  logic              abort,
    output logic [DVSR_W-1:0] dvsr,
    output logic              busy,
    output logic              locked,
    output logic              done,
    output logic              err
);

    import uart_pkg::*;

    // N can reach 2^CNT_W, and N + 64 must not overflow
    localparam int          NW        = CNT_W + 1;
    localparam logic [1:0]  LAST_EDGE = 2'(SYNC_BITS / 2 - 1);

    ab_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          edges_q, edges_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DVSR_W-1:0]   dvsr_q, dvsr_d;
    logic                locked_q, locked_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                w_fe;
    logic [NW-1:0]       w_sum;
    logic [NW-1:0]       w_q;
    logic [31:0]         w_q32;
    logic                w_bad;
    logic [DVSR_W-1:0]   w_new;

    uart_rx_sync_edge u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .rx_i  (rx),
        .fe_o  (w_fe)
    );

    // Rounded quotient and range check; q - 1 is checked before truncation
    assign w_sum = n_q + NW'(ROUND_C);
    assign w_q   = w_sum >> Q_SHIFT;
    assign w_q32 = 32'(w_q);
    assign w_bad = (w_q32 < 32'd2) || (w_q32 > (32'd1 << DVSR_W));
    assign w_new = DVSR_W'(w_q32 - 32'd1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            edges_q  <= '0;
            n_q      <= '0;
            dvsr_q   <= DVSR_W'(DEFAULT_DVSR);
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edges_q  <= edges_d;
            n_q      <= n_d;
            dvsr_q   <= dvsr_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; abort outranks every other event in a busy state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edges_d  = edges_q;
        n_d      = n_q;
        dvsr_d   = dvsr_q;
        locked_d = locked_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    state_d  = ST_ARMED;
                    locked_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_fe) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                    edges_d = '0;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_fe && (edges_q == LAST_EDGE)) begin
                    n_d     = {1'b0, cnt_q} + NW'(1);
                    state_d = ST_CALC;
                end else if (cnt_q == {CNT_W{1'b1}}) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_fe) begin
                        edges_d = edges_q + 2'd1;
                    end
                end
            end
            ST_CALC: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    if (w_bad) begin
                        err_d = 1'b1;
                    end else begin
                        dvsr_d   = w_new;
                        locked_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dvsr   = dvsr_q;
    assign busy   = (state_q != ST_IDLE);
    assign locked = locked_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_autobaud_ctrl
// Description : Directed bench for uart_autobaud_ctrl with a timestamp-based
//               reference model checked every cycle, plus literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_autobaud_ctrl;

    localparam int TB_DVSR_W  = 11;
    // Narrow counter keeps the timeout case short
    localparam int TB_CNT_W   = 14;
    localparam int TB_DEFAULT = 650;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rx = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [TB_DVSR_W-1:0] dvsr;
    logic                 busy;
    logic                 locked;
    logic                 done;
    logic                 err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    uart_autobaud_ctrl #(
        .DVSR_W       (TB_DVSR_W),
        .CNT_W        (TB_CNT_W),
        .DEFAULT_DVSR (TB_DEFAULT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .start  (start),
        .abort  (abort),
        .dvsr   (dvsr),
        .busy   (busy),
        .locked (locked),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A falling edge on rx becomes visible to the controller two edges after
    // it is first sampled. N is the cycle distance between the first and the
    // fifth visible falling edge after arming.
    int   cyc = 0;
    int   m_mode = 0;       // 0 idle, 1 armed, 2 measuring, 3 calculating
    int   m_t0 = 0;
    int   m_edges = 0;
    int   m_n = 0;
    int   m_dvsr = TB_DEFAULT;
    bit   m_locked = 1'b0;
    bit   m_done = 1'b0;
    bit   m_err = 1'b0;
    logic rx_d1 = 1'b1, rx_d2 = 1'b1, rx_d3 = 1'b1;

    function automatic int quot(input int n);
        return (n + 64) / 128;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_mode   <= 0;
            m_dvsr   <= TB_DEFAULT;
            m_locked <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            rx_d1    <= 1'b1;
            rx_d2    <= 1'b1;
            rx_d3    <= 1'b1;
        end else begin
            rx_d1  <= rx;
            rx_d2  <= rx_d1;
            rx_d3  <= rx_d2;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            case (m_mode)
                0: if (!abort && start) begin
                       m_mode   <= 1;
                       m_locked <= 1'b0;
                   end
                1: if (abort) m_mode <= 0;
                   else if (rx_d2 == 1'b0 && rx_d3 == 1'b1) begin
                       m_mode  <= 2;
                       m_t0    <= cyc;
                       m_edges <= 0;
                   end
                2: if (abort) m_mode <= 0;
                   else if (rx_d2 == 1'b0 && rx_d3 == 1'b1 && m_edges == 3) begin
                       m_n    <= cyc - m_t0;
                       m_mode <= 3;
                   end else if (cyc - m_t0 == 2 ** TB_CNT_W) begin
                       m_err  <= 1'b1;
                       m_mode <= 0;
                   end else if (rx_d2 == 1'b0 && rx_d3 == 1'b1) begin
                       m_edges <= m_edges + 1;
                   end
                3: begin
                       m_mode <= 0;
                       if (!abort) begin
                           if (quot(m_n) < 2 || quot(m_n) - 1 > 2 ** TB_DVSR_W - 1) begin
                               m_err <= 1'b1;
                           end else begin
                               m_dvsr   <= quot(m_n) - 1;
                               m_locked <= 1'b1;
                               m_done   <= 1'b1;
                           end
                       end
                   end
                default: m_mode <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dvsr !== TB_DVSR_W'(m_dvsr) || busy !== (m_mode != 0) ||
                locked !== m_locked || done !== m_done || err !== m_err) begin
                errors++;
                $display("FAIL model_cycle t=%0t: dut dvsr=%0d busy=%b locked=%b done=%b err=%b, model dvsr=%0d busy=%b locked=%b done=%b err=%b",
                         $time, dvsr, busy, locked, done, err,
                         m_dvsr, (m_mode != 0), m_locked, m_done, m_err);
            end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0x55 LSB first; 'late' delays the fifth falling edge
    task automatic send_frame(input int bt, input int late);
        rx = 1'b0;
        idle(bt);
        for (int b = 0; b < 8; b++) begin
            rx = (b % 2 == 0);
            idle(bt + ((b == 6) ? late : 0));
        end
        rx = 1'b1;
        idle(bt);
    endtask

    // ---------------- directed sequence ----------------
    int d0, e0;
    bit hit;

    initial begin
        tick();
        chk_en = 1'b1;
        idle(2);
        expect_eq("reset_dvsr", 32'(dvsr), 32'd650);
        expect_eq("reset_busy", 32'(busy), 32'd0);
        expect_eq("reset_locked", 32'(locked), 32'd0);
        reset = 1'b0;
        idle(3);

        // Lock at 115200 baud: bit time 432 -> N 3456 -> dvsr 26
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        expect_eq("armed_busy", 32'(busy), 32'd1);
        idle(5);
        send_frame(432, 0);
        idle(20);
        expect_eq("lock115k_dvsr", 32'(dvsr), 32'd26);
        expect_eq("lock115k_locked", 32'(locked), 32'd1);
        expect_eq("lock115k_done", 32'(done_cnt - d0), 32'd1);
        expect_eq("lock115k_err", 32'(err_cnt - e0), 32'd0);

        // Final edge 50 cycles late still rounds to 27
        pulse_start();
        send_frame(432, 50);
        idle(20);
        expect_eq("late50_dvsr", 32'(dvsr), 32'd26);

        // Final edge 70 cycles late rounds to 28
        pulse_start();
        send_frame(432, 70);
        idle(20);
        expect_eq("late70_dvsr", 32'(dvsr), 32'd27);

        // Too fast: N 128 -> q 1 -> error, divisor stays at default
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        send_frame(16, 0);
        idle(20);
        expect_eq("fast_err", 32'(err_cnt - e0), 32'd1);
        expect_eq("fast_dvsr", 32'(dvsr), 32'd650);
        expect_eq("fast_locked", 32'(locked), 32'd0);

        // Timeout: a single falling edge, then idle line
        e0 = err_cnt;
        pulse_start();
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < (2 ** TB_CNT_W) + 200 && !hit; i++) begin
            tick();
            if (err_cnt != e0) hit = 1'b1;
        end
        expect_eq("timeout_err", 32'(hit), 32'd1);
        idle(2);
        expect_eq("timeout_busy", 32'(busy), 32'd0);
        expect_eq("timeout_dvsr", 32'(dvsr), 32'd650);

        // Abort after two edges, then a clean lock
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        rx = 1'b0; idle(432);
        rx = 1'b1; idle(432);
        rx = 1'b0; idle(100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_eq("abort_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        idle(600);
        expect_eq("abort_done", 32'(done_cnt - d0), 32'd0);
        expect_eq("abort_err", 32'(err_cnt - e0), 32'd0);
        expect_eq("abort_dvsr", 32'(dvsr), 32'd650);
        pulse_start();
        send_frame(432, 0);
        idle(20);
        expect_eq("relock_dvsr", 32'(dvsr), 32'd26);
        expect_eq("relock_locked", 32'(locked), 32'd1);

        // start during MEASURE is ignored: bit time 300 -> N 2400 -> dvsr 18
        d0 = done_cnt;
        pulse_start();
        fork
            send_frame(300, 0);
            begin
                idle(1000);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        idle(20);
        expect_eq("ignore_dvsr", 32'(dvsr), 32'd18);
        expect_eq("ignore_done", 32'(done_cnt - d0), 32'd1);

        // Reset while calculating returns everything to reset values
        d0 = done_cnt;
        pulse_start();
        hit = 1'b0;
        fork
            send_frame(432, 0);
            begin
                for (int i = 0; i < 5000 && !hit; i++) begin
                    tick();
                    if (m_mode == 3) begin
                        reset = 1'b1;
                        tick();
                        expect_eq("calcrst_dvsr", 32'(dvsr), 32'd650);
                        expect_eq("calcrst_busy", 32'(busy), 32'd0);
                        expect_eq("calcrst_locked", 32'(locked), 32'd0);
                        reset = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        expect_eq("calcrst_reached", 32'(hit), 32'd1);
        idle(20);
        expect_eq("calcrst_done", 32'(done_cnt - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
